// File: rtl/pll_sched_pkg.sv
// pll_sched_pkg
//   Shared definitions for the ADF4159 load/pre_load scheduler:
//   default channel count, FSM state encoding and requester source codes.
package pll_sched_pkg;

    localparam int unsigned NUM_CH_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_LOCK_CHK
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_TX,
        SRC_RX,
        SRC_CFG
    } src_t;

endpackage

// File: rtl/pll_load_sched_if.sv
// pll_load_sched_if
//   Bundle between the requesters / serialiser channels and the scheduler.
//   master : requester and channel side (drives requests, busy, lock detect)
//   slave  : scheduler side (drives strobes and status)
//   Signals:
//     tx_req/tx_mask, rx_req/rx_mask, cfg_req/cfg_mask : request pulses + channel sets
//     busy, pll_lock_i                                 : per-channel status in
//     load, pre_load                                   : per-channel strobes out
//     pend, sched_busy, err_timeout, lock_fail         : scheduler status out
interface pll_load_sched_if
    import pll_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF
) ();

    logic              tx_req;
    logic [NUM_CH-1:0] tx_mask;
    logic              rx_req;
    logic [NUM_CH-1:0] rx_mask;
    logic              cfg_req;
    logic [NUM_CH-1:0] cfg_mask;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] pll_lock_i;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] pre_load;
    logic [NUM_CH-1:0] pend;
    logic              sched_busy;
    logic              err_timeout;
    logic [NUM_CH-1:0] lock_fail;

    modport master (
        output tx_req, tx_mask, rx_req, rx_mask, cfg_req, cfg_mask, busy, pll_lock_i,
        input  load, pre_load, pend, sched_busy, err_timeout, lock_fail
    );

    modport slave (
        input  tx_req, tx_mask, rx_req, rx_mask, cfg_req, cfg_mask, busy, pll_lock_i,
        output load, pre_load, pend, sched_busy, err_timeout, lock_fail
    );

endinterface

// File: rtl/pll_load_sched_req_latch.sv
// sched_req_latch
//   Pending channel-mask register for one requester.
//   Ports:
//     clk, rst : clock, synchronous active-low reset
//     set      : request pulse, ORs mask into pend (ignored when mask is 0)
//     mask     : channel set carried by the request
//     clr      : scheduler has taken the pending set
//     pend     : accumulated pending channel set
//   A set arriving in the same cycle as clr survives, so a re-request is
//   serviced in the following round.
module sched_req_latch
    import pll_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [NUM_CH-1:0] mask,
    input  logic              clr,
    output logic [NUM_CH-1:0] pend
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend <= '0;
        end else if (set && (mask != '0)) begin
            pend <= (clr ? '0 : pend) | mask;
        end else if (clr) begin
            pend <= '0;
        end
    end

endmodule

// File: rtl/pll_load_sched.sv
// pll_load_sched
//   Sequences load / pre_load strobes to the ADF4159 serialiser channels for
//   three requesters (TX trigger, RX trigger, host config), priority TX > RX > CFG.
//   A granted set waits until its channels are idle, is strobed, and the strobe
//   is held until all granted channels report busy or ACK_TIMEOUT expires.
//   Ports:
//     clk  : system clock
//     rst  : synchronous, active-low reset
//     bus  : pll_load_sched_if.slave (requests, busy, lock in; strobes, status out)
//   Optional feature: define PLL_LOCK_CHECK_EN to add a post-load lock check
//   that waits LOCK_WAIT cycles after the channels go idle and records
//   per-channel lock failures in lock_fail. Without it lock_fail is 0.
module pll_load_sched
    import pll_sched_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned LOCK_WAIT   = 3000
) (
    input  logic             clk,
    input  logic             rst,
    pll_load_sched_if.slave  bus
);

    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

    state_t            state;
    src_t              src;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] grant_busy;
    logic [7:0]        ack_cnt;

    logic [NUM_CH-1:0] pend_tx, pend_rx, pend_cfg;
    logic              clr_tx, clr_rx, clr_cfg;

    sched_req_latch #(.NUM_CH(NUM_CH)) u_tx (
        .clk(clk), .rst(rst), .set(bus.tx_req), .mask(bus.tx_mask), .clr(clr_tx), .pend(pend_tx)
    );
    sched_req_latch #(.NUM_CH(NUM_CH)) u_rx (
        .clk(clk), .rst(rst), .set(bus.rx_req), .mask(bus.rx_mask), .clr(clr_rx), .pend(pend_rx)
    );
    sched_req_latch #(.NUM_CH(NUM_CH)) u_cfg (
        .clk(clk), .rst(rst), .set(bus.cfg_req), .mask(bus.cfg_mask), .clr(clr_cfg), .pend(pend_cfg)
    );

    assign bus.pend   = pend_tx | pend_rx | pend_cfg;
    assign grant_busy = bus.busy & grant;

    // Arbitration only in IDLE; the chosen source's pending set is taken whole.
    always_comb begin
        clr_tx  = 1'b0;
        clr_rx  = 1'b0;
        clr_cfg = 1'b0;
        if (state == ST_IDLE) begin
            if (pend_tx != '0)       clr_tx  = 1'b1;
            else if (pend_rx != '0)  clr_rx  = 1'b1;
            else if (pend_cfg != '0) clr_cfg = 1'b1;
        end
    end

`ifdef PLL_LOCK_CHECK_EN
    localparam int unsigned LW_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;
    localparam logic [LW_W-1:0] LOCK_LAST = LW_W'(LOCK_WAIT - 1);

    logic            timed_out;
    logic            lock_armed;
    logic [LW_W-1:0] lock_cnt;
`else
    logic unused_lock;
    assign unused_lock   = ^bus.pll_lock_i;
    assign bus.lock_fail = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ST_IDLE;
            src             <= SRC_NONE;
            grant           <= '0;
            ack_cnt         <= '0;
            bus.load        <= '0;
            bus.pre_load    <= '0;
            bus.sched_busy  <= 1'b0;
            bus.err_timeout <= 1'b0;
`ifdef PLL_LOCK_CHECK_EN
            timed_out       <= 1'b0;
            lock_armed      <= 1'b0;
            lock_cnt        <= '0;
            bus.lock_fail   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_tx) begin
                        grant <= pend_tx;
                        src   <= SRC_TX;
                    end else if (clr_rx) begin
                        grant <= pend_rx;
                        src   <= SRC_RX;
                    end else if (clr_cfg) begin
                        grant <= pend_cfg;
                        src   <= SRC_CFG;
                    end
                    if (clr_tx || clr_rx || clr_cfg) begin
                        state          <= ST_WAIT_IDLE;
                        bus.sched_busy <= 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (grant_busy == '0) begin
                        if (src == SRC_CFG) bus.pre_load <= grant;
                        else                bus.load     <= grant;
                        ack_cnt <= '0;
                        state   <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
`ifdef PLL_LOCK_CHECK_EN
                    timed_out <= 1'b0;
`endif
                    if (grant_busy == grant) begin
                        bus.load     <= '0;
                        bus.pre_load <= '0;
                        state        <= ST_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        bus.load        <= '0;
                        bus.pre_load    <= '0;
                        bus.err_timeout <= 1'b1;
                        state           <= ST_DONE;
`ifdef PLL_LOCK_CHECK_EN
                        timed_out       <= 1'b1;
`endif
                    end else if (ack_cnt != '1) begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
`ifdef PLL_LOCK_CHECK_EN
                    if (timed_out) begin
                        state          <= ST_IDLE;
                        bus.sched_busy <= 1'b0;
                    end else begin
                        state      <= ST_LOCK_CHK;
                        lock_armed <= 1'b0;
                        lock_cnt   <= '0;
                    end
`else
                    state          <= ST_IDLE;
                    bus.sched_busy <= 1'b0;
`endif
                end

`ifdef PLL_LOCK_CHECK_EN
                // Two phases: wait for the granted channels to finish
                // serialising, then let the PLLs settle before sampling lock.
                ST_LOCK_CHK: begin
                    if (!lock_armed) begin
                        if (grant_busy == '0) begin
                            lock_armed <= 1'b1;
                            lock_cnt   <= '0;
                        end
                    end else if (lock_cnt == LOCK_LAST) begin
                        bus.lock_fail  <= bus.lock_fail | (grant & ~bus.pll_lock_i);
                        lock_armed     <= 1'b0;
                        state          <= ST_IDLE;
                        bus.sched_busy <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    state          <= ST_IDLE;
                    bus.sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_load_sched.sv
// tb_pll_load_sched
//   Directed bench for pll_load_sched: a per-cycle vector table for single
//   and simultaneous requests, plus hand sequences for busy stall, ack
//   timeout, mid-operation reset and (with PLL_LOCK_CHECK_EN) lock check.
module tb_pll_load_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pll_load_sched_if #(.NUM_CH(6)) bus ();

    pll_load_sched #(.NUM_CH(6), .ACK_TIMEOUT(255), .LOCK_WAIT(3000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       tx_req;
        logic [5:0] tx_mask;
        logic       rx_req;
        logic [5:0] rx_mask;
        logic       cfg_req;
        logic [5:0] cfg_mask;
        logic [5:0] busy;
        logic [5:0] exp_load;
        logic [5:0] exp_pre;
        logic [5:0] exp_pend;
        logic       exp_sb;
    } vec_t;

    vec_t tbl[22];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic txr, input logic [5:0] txm, input logic rxr, input logic [5:0] rxm,
                         input logic cfr, input logic [5:0] cfm, input logic [5:0] bsy);
        bus.tx_req   = txr;
        bus.tx_mask  = txm;
        bus.rx_req   = rxr;
        bus.rx_mask  = rxm;
        bus.cfg_req  = cfr;
        bus.cfg_mask = cfm;
        bus.busy     = bsy;
    endtask

    function automatic vec_t mk(input logic txr, input logic [5:0] txm, input logic rxr, input logic [5:0] rxm,
                                input logic cfr, input logic [5:0] cfm, input logic [5:0] bsy,
                                input logic [5:0] el, input logic [5:0] ep, input logic [5:0] epd,
                                input logic esb);
        vec_t v;
        v.tx_req = txr; v.tx_mask = txm; v.rx_req = rxr; v.rx_mask = rxm;
        v.cfg_req = cfr; v.cfg_mask = cfm; v.busy = bsy;
        v.exp_load = el; v.exp_pre = ep; v.exp_pend = epd; v.exp_sb = esb;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;

        // single TX request, ack on cycle 5
        tbl[0]  = mk(1, 6'h13, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 0);
        tbl[1]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h13, 0);
        tbl[2]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1);
        tbl[3]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h13, 6'h00, 6'h00, 1);
        tbl[4]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h13, 6'h00, 6'h00, 1);
        tbl[5]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h13, 6'h13, 6'h00, 6'h00, 1);
        tbl[6]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h13, 6'h00, 6'h00, 6'h00, 1);
        tbl[7]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 0);
        // TX, RX, CFG on the same cycle -> serviced TX, RX, CFG
        tbl[8]  = mk(1, 6'h01, 1, 6'h02, 1, 6'h04, 6'h00, 6'h00, 6'h00, 6'h00, 0);
        tbl[9]  = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h07, 0);
        tbl[10] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h06, 1);
        tbl[11] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h01, 6'h01, 6'h00, 6'h06, 1);
        tbl[12] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h06, 1);
        tbl[13] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h06, 0);
        tbl[14] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 1);
        tbl[15] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h02, 6'h02, 6'h00, 6'h04, 1);
        tbl[16] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 1);
        tbl[17] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 0);
        tbl[18] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1);
        tbl[19] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h04, 6'h00, 6'h04, 6'h00, 1);
        tbl[20] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1);
        tbl[21] = mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 0);

        drive(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00);
        bus.pll_lock_i = '1;
        rst = 1'b0;
        tick();
        tick();
        check("reset load", 32'(bus.load), 32'h0);
        check("reset pre_load", 32'(bus.pre_load), 32'h0);
        check("reset pend", 32'(bus.pend), 32'h0);
        check("reset sched_busy", 32'(bus.sched_busy), 32'h0);
        check("reset err_timeout", 32'(bus.err_timeout), 32'h0);
        check("reset lock_fail", 32'(bus.lock_fail), 32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].tx_req, tbl[i].tx_mask, tbl[i].rx_req, tbl[i].rx_mask,
                  tbl[i].cfg_req, tbl[i].cfg_mask, tbl[i].busy);
            check($sformatf("vec%0d load", i), 32'(bus.load), 32'(tbl[i].exp_load));
            check($sformatf("vec%0d pre_load", i), 32'(bus.pre_load), 32'(tbl[i].exp_pre));
            check($sformatf("vec%0d pend", i), 32'(bus.pend), 32'(tbl[i].exp_pend));
            check($sformatf("vec%0d sched_busy", i), 32'(bus.sched_busy), 32'(tbl[i].exp_sb));
            check($sformatf("vec%0d err_timeout", i), 32'(bus.err_timeout), 32'h0);
            tick();
        end
        drive(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00);

        // busy channel stalls WAIT_IDLE
        drive(1, 6'h01, 0, 6'h00, 0, 6'h00, 6'h01);
        tick();
        drive(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h01);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d load", i), 32'(bus.load), 32'h0);
            check($sformatf("stall%0d sched_busy", i), 32'(bus.sched_busy), 32'h1);
            tick();
        end
        bus.busy = 6'h00;
        check("stall release load", 32'(bus.load), 32'h0);
        tick();
        check("stall strobe load", 32'(bus.load), 32'h01);
        bus.busy = 6'h01;
        tick();
        check("stall ack load", 32'(bus.load), 32'h0);
        bus.busy = 6'h00;
        tick();
        check("stall idle sched_busy", 32'(bus.sched_busy), 32'h0);

        // never acked -> timeout after 255 strobe cycles
        drive(1, 6'h20, 0, 6'h00, 0, 6'h00, 6'h00);
        tick();
        drive(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.load != '0) seen = 1'b1;
            else tick();
        end
        check("timeout strobe seen", 32'(seen), 32'h1);
        cnt = 0;
        while (bus.load == 6'h20 && cnt < 300) begin
            cnt++;
            tick();
        end
        check("timeout hold cycles", 32'(cnt), 32'd255);
        check("timeout load dropped", 32'(bus.load), 32'h0);
        check("timeout err_timeout", 32'(bus.err_timeout), 32'h1);
        tick();
        check("timeout back idle", 32'(bus.sched_busy), 32'h0);

        // queued RX request then reset in WAIT_ACK
        drive(1, 6'h01, 0, 6'h00, 0, 6'h00, 6'h00);
        tick();
        drive(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00);
        tick();
        tick();
        drive(0, 6'h00, 1, 6'h02, 0, 6'h00, 6'h00);
        check("rstmid strobe", 32'(bus.load), 32'h01);
        tick();
        drive(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00);
        check("rstmid queued pend", 32'(bus.pend), 32'h02);
        check("rstmid still strobing", 32'(bus.load), 32'h01);
        rst = 1'b0;
        tick();
        check("rstmid load", 32'(bus.load), 32'h0);
        check("rstmid pend", 32'(bus.pend), 32'h0);
        check("rstmid sched_busy", 32'(bus.sched_busy), 32'h0);
        check("rstmid err_timeout", 32'(bus.err_timeout), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rstmid noretry%0d load", i), 32'(bus.load), 32'h0);
            check($sformatf("rstmid noretry%0d busy", i), 32'(bus.sched_busy), 32'h0);
        end

        // lock check
        bus.pll_lock_i = 6'h01;
        drive(1, 6'h03, 0, 6'h00, 0, 6'h00, 6'h00);
        tick();
        drive(0, 6'h00, 0, 6'h00, 0, 6'h00, 6'h00);
        tick();
        tick();
        check("lock strobe", 32'(bus.load), 32'h03);
        bus.busy = 6'h03;
        tick();
        bus.busy = 6'h00;
        cnt = 0;
        while (bus.sched_busy && cnt < 4000) begin
            cnt++;
            tick();
        end
        check("lock finished in bound", 32'(cnt < 4000), 32'h1);
`ifdef PLL_LOCK_CHECK_EN
        check("lock_fail", 32'(bus.lock_fail), 32'h02);
`else
        check("lock_fail tied", 32'(bus.lock_fail), 32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
